control_pipe: RTL and testbench

Parametrised, pipelined successor to the single-register MIPS control decoder. Decodes `op`/`funct` into the control bundle and carries it through a STAGES-deep shift of valid-tagged stage registers (EX, MEM, WB). Adds external stall, branch flush and a load-use interlock that holds the front end and inserts a bubble. Sits between instruction fetch and the datapath; each datapath stage reads its control fields from the matching stage output.

---
 rtl/control_pipe.sv | 137 +++++++++++++
 tb/tb_control_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Pipelined MIPS control decoder: decodes op/funct into a control bundle and
// carries it through STAGES valid-tagged stage registers with stall, flush and load-use interlock.
module control_pipe #(
  parameter int STAGES   = 3,
  parameter int ALU_OP_W = 5,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic                stall_ext,
  input  logic                flush,
  output logic                in_ready,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                i_or_r,
  output logic                branch,
  output logic                jump,
  output logic                mem_valid,
  output logic                load,
  output logic                bus_write,
  output logic                wb_valid,
  output logic                reg_write,
  output logic [REG_W-1:0]    wb_dest,
  output logic [CNT_W-1:0]    interlock_count
);

  localparam int MEM_S = STAGES - 1;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                i_or_r;
    logic                branch;
    logic                jump;
    logic                load;
    logic                bus_write;
    logic                reg_write;
    logic [REG_W-1:0]    dest;
  } ctrl_t;

  ctrl_t                dec;
  logic [5:0]           alu6;
  logic [ALU_OP_W-1:0]  alu_sized;
  logic                 is_r;
  logic                 interlock;

  ctrl_t                stage_reg [1:STAGES];
  logic                 valid_reg [1:STAGES];
  logic [CNT_W-1:0]     count_reg;

  assign is_r = (op == 6'd0);

  always_comb begin
    alu6 = funct;
    if (op[5]) begin
      alu6 = 6'd0;
    end else if (!is_r) begin
      alu6 = (op[3] ? 6'd0 : 6'd16) | op;
      if (op == 6'b011100) begin
        alu6 = alu6 | funct;
      end
    end
  end

  // Narrow ALU codes keep the low bits; wide ones are zero-extended.
  generate
    if (ALU_OP_W <= 6) begin : g_alu_trunc
      assign alu_sized = alu6[ALU_OP_W-1:0];
    end else begin : g_alu_ext
      assign alu_sized = {{(ALU_OP_W-6){1'b0}}, alu6};
    end
  endgenerate

  always_comb begin
    dec           = '0;
    dec.alu_op    = alu_sized;
    dec.i_or_r    = is_r;
    dec.reg_write = (op[5] ^ op[3]) | is_r;
    dec.bus_write = op[5] & op[3];
    dec.load      = op[5] & ~op[3];
    dec.branch    = ~op[5] & ~op[3] & (op[2] | (~op[1] & op[0]));
    dec.jump      = ~op[5] & ~op[3] & ~op[2] & op[1];
    dec.dest      = is_r ? rd : rt;
  end

  // A load in EX whose destination feeds the decoding instruction holds the front end one cycle.
  assign interlock = in_valid & valid_reg[1] & stage_reg[1].load
                   & (stage_reg[1].dest != '0)
                   & ((stage_reg[1].dest == rs) | ((stage_reg[1].dest == rt) & is_r));

  assign in_ready = ~stall_ext & ~interlock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        stage_reg[k] <= '0;
      end
      count_reg <= '0;
    end else if (!stall_ext) begin
      for (int k = 2; k <= STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        stage_reg[k] <= stage_reg[k-1];
      end
      stage_reg[1] <= dec;
      valid_reg[1] <= in_valid & in_ready & ~flush;
      if (interlock && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end else if (flush) begin
      valid_reg[1] <= 1'b0;
    end
  end

  assign ex_valid  = valid_reg[1];
  assign alu_op    = valid_reg[1] ? stage_reg[1].alu_op : '0;
  assign i_or_r    = valid_reg[1] & stage_reg[1].i_or_r;
  assign branch    = valid_reg[1] & stage_reg[1].branch;
  assign jump      = valid_reg[1] & stage_reg[1].jump;

  assign mem_valid = valid_reg[MEM_S];
  assign load      = valid_reg[MEM_S] & stage_reg[MEM_S].load;
  assign bus_write = valid_reg[MEM_S] & stage_reg[MEM_S].bus_write;

  assign wb_valid  = valid_reg[STAGES];
  assign reg_write = valid_reg[STAGES] & stage_reg[STAGES].reg_write;
  assign wb_dest   = stage_reg[STAGES].dest;

  assign interlock_count = count_reg;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: a per-stage instruction model compared every cycle,
// plus directed literal checks for decode, interlock, stall, flush, reset and saturation.
module tb_control_pipe;
  localparam int S    = 4;
  localparam int AW   = 5;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          stall_ext = 1'b0;
  logic          flush = 1'b0;
  logic [5:0]    op = '0;
  logic [5:0]    funct = '0;
  logic [RW-1:0] rs = '0;
  logic [RW-1:0] rt = '0;
  logic [RW-1:0] rd = '0;

  logic          in_ready, ex_valid, i_or_r, branch, jump;
  logic          mem_valid, load, bus_write, wb_valid, reg_write;
  logic [AW-1:0] alu_op;
  logic [RW-1:0] wb_dest;
  logic [CW-1:0] interlock_count;

  int n_checks = 0;
  int n_pass   = 0;

  control_pipe #(.STAGES(S), .ALU_OP_W(AW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .stall_ext(stall_ext), .flush(flush),
    .in_ready(in_ready), .ex_valid(ex_valid), .alu_op(alu_op), .i_or_r(i_or_r),
    .branch(branch), .jump(jump), .mem_valid(mem_valid), .load(load),
    .bus_write(bus_write), .wb_valid(wb_valid), .reg_write(reg_write),
    .wb_dest(wb_dest), .interlock_count(interlock_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] alu;
    logic          i_or_r;
    logic          branch;
    logic          jump;
    logic          load;
    logic          bus_write;
    logic          reg_write;
    logic [RW-1:0] dest;
  } bundle_t;

  // Decode rules written as integer arithmetic on the opcode value.
  function automatic bundle_t decode(input int o, input int f, input int t, input int d);
    bundle_t b;
    int a;
    b           = '0;
    b.i_or_r    = (o == 0);
    b.load      = (o >= 32) && ((o & 8) == 0);
    b.bus_write = (o >= 32) && ((o & 8) != 0);
    b.reg_write = (o == 0) || ((o >= 32) != ((o & 8) != 0));
    b.branch    = (o < 32) && ((o & 8) == 0) && (((o & 4) != 0) || ((o & 3) == 1));
    b.jump      = (o < 32) && ((o & 14) == 2);
    if (o >= 32)      a = 0;
    else if (o == 0)  a = f;
    else begin
      a = (((o & 8) != 0) ? 0 : 16) | o;
      if (o == 28) a = a | f;
    end
    b.alu  = AW'(a & ((1 << AW) - 1));
    b.dest = RW'((o == 0) ? d : t);
    return b;
  endfunction

  bundle_t m_b [1:S];
  logic    m_v [1:S];
  int      m_cnt;
  logic    m_il;
  logic    m_ready;

  assign m_il = in_valid && m_v[1] && m_b[1].load && (m_b[1].dest != 0)
             && ((m_b[1].dest == rs) || ((m_b[1].dest == rt) && (op == 0)));
  assign m_ready = !stall_ext && !m_il;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= S; k++) begin
        m_v[k] <= 1'b0;
        m_b[k] <= '0;
      end
      m_cnt <= 0;
    end else if (!stall_ext) begin
      for (int k = S; k >= 2; k--) begin
        m_v[k] <= m_v[k-1];
        m_b[k] <= m_b[k-1];
      end
      m_b[1] <= decode(int'(op), int'(funct), int'(rt), int'(rd));
      m_v[1] <= in_valid && !m_il && !flush;
      if (m_il && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end else if (flush) begin
      m_v[1] <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    check("m_in_ready",  in_ready,  m_ready);
    check("m_ex_valid",  ex_valid,  m_v[1]);
    check("m_alu_op",    alu_op,    m_v[1] ? m_b[1].alu : '0);
    check("m_i_or_r",    i_or_r,    m_v[1] & m_b[1].i_or_r);
    check("m_branch",    branch,    m_v[1] & m_b[1].branch);
    check("m_jump",      jump,      m_v[1] & m_b[1].jump);
    check("m_mem_valid", mem_valid, m_v[S-1]);
    check("m_load",      load,      m_v[S-1] & m_b[S-1].load);
    check("m_bus_write", bus_write, m_v[S-1] & m_b[S-1].bus_write);
    check("m_wb_valid",  wb_valid,  m_v[S]);
    check("m_reg_write", reg_write, m_v[S] & m_b[S].reg_write);
    check("m_wb_dest",   wb_dest,   m_b[S].dest);
    check("m_count",     interlock_count, m_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f,
                       input logic [RW-1:0] s, input logic [RW-1:0] t, input logic [RW-1:0] d);
    in_valid = 1'b1; op = o; funct = f; rs = s; rt = t; rd = d;
    $display("issue op=%02h funct=%02h rs=%0d rt=%0d rd=%0d stall=%0b flush=%0b",
             o, f, s, t, d, stall_ext, flush);
  endtask

  task automatic idle();
    in_valid = 1'b0; op = '0; funct = '0; rs = '0; rt = '0; rd = '0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    cyc();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_count", interlock_count, 0);
    check("rst_ready", in_ready, 1);

    // ADDU through to WB
    issue(6'h00, 6'h21, 1, 2, 3); #1 check("addu_ready", in_ready, 1);
    cyc();
    check("addu_ex_valid", ex_valid, 1);
    check("addu_alu", alu_op, 5'h01);
    check("addu_i_or_r", i_or_r, 1);
    idle(); cyc(); cyc(); cyc();
    check("addu_wb_valid", wb_valid, 1);
    check("addu_reg_write", reg_write, 1);
    check("addu_wb_dest", wb_dest, 3);

    // ORI: o3=1 so no 16 term, alu = 0x0D
    issue(6'h0D, 6'h00, 0, 7, 0); cyc();
    check("ori_alu", alu_op, 5'h0D);
    check("ori_i_or_r", i_or_r, 0);
    issue(6'h04, 6'h00, 1, 2, 0); cyc();
    check("beq_branch", branch, 1);
    check("beq_alu", alu_op, 5'h14);
    issue(6'h02, 6'h00, 0, 0, 0); cyc();
    check("j_jump", jump, 1);
    check("j_branch", branch, 0);
    issue(6'h1C, 6'h20, 0, 9, 0); cyc();
    check("clz_alu", alu_op, 5'h1C);
    check("ori_wb_valid", wb_valid, 1);
    check("ori_wb_dest", wb_dest, 7);
    check("ori_reg_write", reg_write, 1);
    idle(); cyc();
    check("beq_wb_valid", wb_valid, 1);
    check("beq_reg_write", reg_write, 0);
    cyc(); cyc(); cyc();

    // Load-use on rs
    issue(6'h23, 6'h00, 0, 5, 0); cyc();
    check("lw_ex_valid", ex_valid, 1);
    issue(6'h00, 6'h21, 5, 6, 8); #1 check("lu_ready_low", in_ready, 0);
    cyc();
    check("lu_bubble", ex_valid, 0);
    check("lu_count", interlock_count, 1);
    check("lu_ready_high", in_ready, 1);
    cyc();
    check("lu_addu_ex", ex_valid, 1);
    check("lu_addu_alu", alu_op, 5'h01);
    check("lu_lw_mem_load", load, 1);
    idle();
    // Load to r0 never interlocks
    issue(6'h23, 6'h00, 0, 0, 0); cyc();
    issue(6'h00, 6'h21, 0, 6, 8); #1 check("r0_ready", in_ready, 1);
    cyc();
    check("r0_ex_valid", ex_valid, 1);
    check("r0_count", interlock_count, 1);
    // rt match counts only for R-type consumers
    issue(6'h23, 6'h00, 0, 4, 0); cyc();
    issue(6'h0D, 6'h00, 1, 4, 0); #1 check("rt_itype_ready", in_ready, 1);
    issue(6'h00, 6'h21, 1, 4, 9); #1 check("rt_rtype_ready", in_ready, 0);
    cyc();
    check("rt_count", interlock_count, 2);
    cyc(); idle();

    // Interlock under stall does not count
    issue(6'h23, 6'h00, 0, 5, 0); cyc();
    issue(6'h00, 6'h21, 5, 6, 8); stall_ext = 1'b1; #1 check("st_il_ready", in_ready, 0);
    cyc();
    check("st_il_count", interlock_count, 2);
    check("st_il_hold", ex_valid, 1);
    stall_ext = 1'b0; cyc();
    check("st_il_count2", interlock_count, 3);
    check("st_il_bubble", ex_valid, 0);
    cyc(); check("st_il_enter", ex_valid, 1);
    idle();

    // Flush with interlock still counts
    issue(6'h23, 6'h00, 0, 5, 0); cyc();
    issue(6'h00, 6'h21, 5, 6, 8); flush = 1'b1; #1 check("fl_il_ready", in_ready, 0);
    cyc();
    check("fl_il_ex", ex_valid, 0);
    check("fl_il_count", interlock_count, 4);
    flush = 1'b0; cyc();
    check("fl_il_enter", ex_valid, 1);
    idle(); cyc(); cyc(); cyc(); cyc();

    // External stall with three in flight, then flush during the stall
    issue(6'h00, 6'h21, 0, 0, 10); cyc();
    issue(6'h0D, 6'h00, 0, 11, 0); cyc();
    issue(6'h2B, 6'h00, 1, 12, 0); cyc();
    issue(6'h08, 6'h00, 0, 13, 0); stall_ext = 1'b1; #1 check("stall_ready", in_ready, 0);
    cyc(); cyc(); cyc();
    check("stall_ex_valid", ex_valid, 1);
    check("stall_sw_alu", alu_op, 0);
    check("stall_mem_valid", mem_valid, 1);
    check("stall_wb_valid", wb_valid, 0);
    flush = 1'b1; cyc();
    check("stall_flush_ex", ex_valid, 0);
    check("stall_flush_mem", mem_valid, 1);
    flush = 1'b0; stall_ext = 1'b0; cyc();
    check("addi_ex", ex_valid, 1);
    check("addi_alu", alu_op, 5'h08);
    check("stall_wb_dest", wb_dest, 10);
    idle(); cyc();
    check("sw_killed_mem", mem_valid, 0);
    cyc(); cyc(); cyc();

    // Branch-taken flush: younger ADDU dropped, older ones retire
    issue(6'h0D, 6'h00, 0, 14, 0); cyc();
    issue(6'h04, 6'h00, 1, 2, 0); cyc();
    issue(6'h00, 6'h21, 1, 2, 13); flush = 1'b1; #1 check("flush_ready", in_ready, 1);
    cyc();
    check("flush_ex", ex_valid, 0);
    flush = 1'b0; idle(); cyc();
    check("flush_ori_wb", wb_valid, 1);
    check("flush_ori_dest", wb_dest, 14);
    cyc();
    check("flush_beq_wb", wb_valid, 1);
    cyc();
    check("flush_addu_gone", wb_valid, 0);

    // Asynchronous reset between edges with a full pipe
    issue(6'h00, 6'h21, 0, 0, 1); cyc();
    issue(6'h0D, 6'h00, 0, 2, 0); cyc();
    issue(6'h2B, 6'h00, 0, 3, 0); cyc();
    issue(6'h08, 6'h00, 0, 4, 0); cyc();
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst_ex", ex_valid, 0);
    check("arst_mem", mem_valid, 0);
    check("arst_wb", wb_valid, 0);
    check("arst_reg_write", reg_write, 0);
    check("arst_wb_dest", wb_dest, 0);
    check("arst_count", interlock_count, 0);
    #2 rst = 1'b0;
    cyc();
    check("arst_after_wb", wb_valid, 0);

    // Saturation: 2^CW+2 interlocks
    for (int i = 1; i <= (1 << CW) + 2; i++) begin
      issue(6'h23, 6'h00, 0, 5, 0); cyc();
      issue(6'h00, 6'h21, 5, 6, 8); cyc(); cyc();
      check("sat_count", interlock_count, (i < CMAX) ? i : CMAX);
    end
    idle();
    check("sat_final", interlock_count, 4'hF);
    cyc(); cyc(); cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
